glue_logic_input: RTL and testbench

GLUE_LOGIC_INPUT -- requirements
Module: glue_logic_input

---
 rtl/glue_logic_input.sv | 199 +++++++++++++++++++
 tb/tb_glue_logic_input.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/glue_logic_input.sv
// ---------------------------------------------------------------------------
// glue_logic_input
//
// Input-side glue for a vectoring-mode CORDIC.  Each accepted Cartesian
// sample (16,14) is folded into the first quadrant so the CORDIC only ever
// sees x >= 0.  The quadrant each sample came from is queued in a small tag
// FIFO, so the output glue can later apply the matching angle correction
// (q2 +pi/2, q3 -pi, q4 -pi/2).
//
// Ports
//   clk           single clock, rising edge
//   reset         synchronous, active-high
//   in_valid      upstream sample present
//   in_ready      block accepts a sample this cycle (combinational)
//   x_in, y_in    signed 16-bit Cartesian sample
//   out_valid     folded sample is valid for the CORDIC
//   out_ready     CORDIC accepts the folded sample
//   x_out, y_out  signed 16-bit first-quadrant-folded coordinates
//   z_out         signed 18-bit initial CORDIC angle (always zero)
//   tag_pop       output glue has consumed one CORDIC result
//   quadrant_out  head-of-FIFO quadrant tag 1..4, or 0 when empty
//   tag_empty     tag FIFO holds no entries
//   tag_full      tag FIFO holds TAG_DEPTH entries
//   tag_err       sticky flag: tag_pop arrived while the FIFO was empty
// ---------------------------------------------------------------------------
module glue_logic_input #(
   parameter int TAG_DEPTH = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic signed [15:0] x_in,
   input  logic signed [15:0] y_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic signed [15:0] x_out,
   output logic signed [15:0] y_out,
   output logic signed [17:0] z_out,
   input  logic               tag_pop,
   output logic [2:0]         quadrant_out,
   output logic               tag_empty,
   output logic               tag_full,
   output logic               tag_err
);

   localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
   localparam int CNT_W = $clog2(TAG_DEPTH + 1);

   // Two's-complement negation with the single overflow case clamped:
   // -(-32768) cannot be represented, so it becomes +32767.
   function automatic logic signed [15:0] sat_neg(input logic signed [15:0] v);
      if (v == 16'sh8000) begin
         return 16'sh7FFF;
      end
      return -v;
   endfunction

   logic               out_valid_q, out_valid_d;
   logic signed [15:0] x_q, x_d;
   logic signed [15:0] y_q, y_d;
   logic signed [17:0] z_q, z_d;

   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               tag_err_q, tag_err_d;
   logic [2:0]         tag_mem_q [TAG_DEPTH];
   logic [2:0]         tag_mem_d [TAG_DEPTH];

   logic               in_xfer;
   logic               out_xfer;
   logic               pop_ok;
   logic [2:0]         quad_tag;
   logic signed [15:0] fold_x;
   logic signed [15:0] fold_y;

   assign tag_empty    = (count_q == '0);
   assign tag_full     = (count_q == CNT_W'(TAG_DEPTH));
   assign in_ready     = (!out_valid_q || out_ready) && !tag_full;
   assign in_xfer      = in_valid && in_ready;
   assign out_xfer     = out_valid_q && out_ready;
   assign pop_ok       = tag_pop && !tag_empty;

   assign out_valid    = out_valid_q;
   assign x_out        = x_q;
   assign y_out        = y_q;
   assign z_out        = z_q;
   assign tag_err      = tag_err_q;
   assign quadrant_out = tag_empty ? 3'd0 : tag_mem_q[rd_ptr_q];

   // Quadrant classification and folding.  Only the sign bits matter, so
   // zero on either axis lands on the "non-negative" side: (0,0)->1,
   // (0,neg)->4, (neg,0)->2.  Each fold is a rotation that brings the
   // point into quadrant 1 without changing its magnitude.
   always_comb begin
      quad_tag = 3'd1;
      fold_x   = x_in;
      fold_y   = y_in;
      unique case ({x_in[15], y_in[15]})
         2'b00: begin
            quad_tag = 3'd1;
            fold_x   = x_in;
            fold_y   = y_in;
         end
         2'b10: begin
            quad_tag = 3'd2;
            fold_x   = y_in;
            fold_y   = sat_neg(x_in);
         end
         2'b11: begin
            quad_tag = 3'd3;
            fold_x   = sat_neg(x_in);
            fold_y   = sat_neg(y_in);
         end
         2'b01: begin
            quad_tag = 3'd4;
            fold_x   = sat_neg(y_in);
            fold_y   = x_in;
         end
         default: begin
            quad_tag = 3'd1;
         end
      endcase
   end

   // Output sample register.  A new input always wins; otherwise a
   // consumed sample drops valid, and an unconsumed one holds.  The
   // CORDIC always starts from angle zero, so z never carries anything.
   always_comb begin
      out_valid_d = out_valid_q;
      x_d         = x_q;
      y_d         = y_q;
      z_d         = z_q;
      if (in_xfer) begin
         out_valid_d = 1'b1;
         x_d         = fold_x;
         y_d         = fold_y;
         z_d         = '0;
      end else if (out_xfer) begin
         out_valid_d = 1'b0;
      end
   end

   // Tag FIFO bookkeeping.  A pop on an empty FIFO is discarded but
   // latched as a protocol error.  A push cannot happen while full
   // because in_ready is already low, so the count never overflows.
   always_comb begin
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      count_d   = count_q;
      tag_err_d = tag_err_q;
      tag_mem_d = tag_mem_q;
      if (in_xfer) begin
         tag_mem_d[wr_ptr_q] = quad_tag;
         wr_ptr_d            = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (tag_pop && tag_empty) begin
         tag_err_d = 1'b1;
      end
      if (in_xfer && !pop_ok) begin
         count_d = count_q + CNT_W'(1);
      end else if (!in_xfer && pop_ok) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // State registers.  Reset discards the held sample and every queued
   // tag; the tag storage itself is left alone since the count gates it.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         x_q         <= '0;
         y_q         <= '0;
         z_q         <= '0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         tag_err_q   <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         x_q         <= x_d;
         y_q         <= y_d;
         z_q         <= z_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         tag_err_q   <= tag_err_d;
      end
   end

   always_ff @(posedge clk) begin
      tag_mem_q <= tag_mem_d;
   end

endmodule

// File: tb/tb_glue_logic_input.sv
// ---------------------------------------------------------------------------
// tb_glue_logic_input
//
// Directed scenarios followed by a randomized run.  A behavioural model
// (a tag queue plus the expected output sample) is advanced once per clock
// edge from the quadrant/fold rules, and every DUT output is compared with
// it after each edge; the directed scenarios add fixed expected values.
// ---------------------------------------------------------------------------
module tb_glue_logic_input;

   localparam int DEPTH = 16;

   logic               clk;
   logic               reset;
   logic               in_valid;
   logic               in_ready;
   logic signed [15:0] x_in;
   logic signed [15:0] y_in;
   logic               out_valid;
   logic               out_ready;
   logic signed [15:0] x_out;
   logic signed [15:0] y_out;
   logic signed [17:0] z_out;
   logic               tag_pop;
   logic [2:0]         quadrant_out;
   logic               tag_empty;
   logic               tag_full;
   logic               tag_err;

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   bit m_valid;
   int m_x;
   int m_y;
   bit m_err;
   int m_q[$];

   glue_logic_input #(.TAG_DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .x_in         (x_in),
      .y_in         (y_in),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .x_out        (x_out),
      .y_out        (y_out),
      .z_out        (z_out),
      .tag_pop      (tag_pop),
      .quadrant_out (quadrant_out),
      .tag_empty    (tag_empty),
      .tag_full     (tag_full),
      .tag_err      (tag_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Negation that clamps the one unrepresentable result.
   function automatic int negSat(input int v);
      return (-v > 32767) ? 32767 : -v;
   endfunction

   task automatic checkOutput(input string name, input logic signed [31:0] observed,
                              input logic signed [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", name, observed, expected);
      end
   endtask

   task automatic checkState();
      bit exp_rdy;
      exp_rdy = (!m_valid || out_ready) && (m_q.size() < DEPTH);
      checkOutput("out_valid", out_valid, m_valid);
      checkOutput("x_out", x_out, m_x);
      checkOutput("y_out", y_out, m_y);
      checkOutput("z_out", z_out, 0);
      checkOutput("tag_empty", tag_empty, m_q.size() == 0);
      checkOutput("tag_full", tag_full, m_q.size() == DEPTH);
      checkOutput("quadrant_out", quadrant_out, (m_q.size() > 0) ? m_q[0] : 0);
      checkOutput("tag_err", tag_err, m_err);
      checkOutput("in_ready", in_ready, exp_rdy);
   endtask

   // Drive one cycle of inputs, advance the model across the edge, then
   // compare every output just after the edge.
   task automatic applyStimulus(input bit iv, input int x, input int y,
                                input bit ordy, input bit pop, input bit rst);
      bit rdy;
      int qd;
      int fx;
      int fy;
      in_valid  = iv;
      x_in      = 16'(x);
      y_in      = 16'(y);
      out_ready = ordy;
      tag_pop   = pop;
      reset     = rst;
      #1;
      rdy = (!m_valid || ordy) && (m_q.size() < DEPTH);
      if (!rst) checkOutput("in_ready_pre", in_ready, rdy);
      if (rst) begin
         m_valid = 0;
         m_x     = 0;
         m_y     = 0;
         m_err   = 0;
         m_q.delete();
      end else begin
         if (pop) begin
            if (m_q.size() > 0) void'(m_q.pop_front());
            else m_err = 1;
         end
         if (iv && rdy) begin
            if (x >= 0 && y >= 0) begin
               qd = 1; fx = x; fy = y;
            end else if (x < 0 && y >= 0) begin
               qd = 2; fx = y; fy = negSat(x);
            end else if (x < 0) begin
               qd = 3; fx = negSat(x); fy = negSat(y);
            end else begin
               qd = 4; fx = negSat(y); fy = x;
            end
            m_valid = 1;
            m_x     = fx;
            m_y     = fy;
            m_q.push_back(qd);
         end else if (m_valid && ordy) begin
            m_valid = 0;
         end
      end
      @(posedge clk);
      #1;
      checkState();
   endtask

   function automatic int randCoord();
      int sel;
      sel = int'($urandom_range(0, 7));
      case (sel)
         0: return -32768;
         1: return 0;
         2: return 32767;
         default: return int'($urandom_range(0, 65535)) - 32768;
      endcase
   endfunction

   initial begin
      in_valid  = 0;
      x_in      = '0;
      y_in      = '0;
      out_ready = 0;
      tag_pop   = 0;
      reset     = 1;
      m_valid   = 0;
      m_x       = 0;
      m_y       = 0;
      m_err     = 0;

      $display("[TB] reset");
      applyStimulus(0, 0, 0, 1, 0, 1);
      applyStimulus(0, 0, 0, 1, 0, 1);
      applyStimulus(0, 0, 0, 1, 0, 0);
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_tag_empty", tag_empty, 1);
      checkOutput("rst_in_ready", in_ready, 1);

      $display("[TB] quadrant 4 fold");
      applyStimulus(1, 16384, -8192, 1, 0, 0);
      checkOutput("q4_valid", out_valid, 1);
      checkOutput("q4_x", x_out, 8192);
      checkOutput("q4_y", y_out, 16384);
      checkOutput("q4_z", z_out, 0);
      checkOutput("q4_tag", quadrant_out, 4);
      applyStimulus(0, 0, 0, 1, 1, 0);
      checkOutput("q4_drained", out_valid, 0);

      $display("[TB] quadrants 2 and 3 with saturation");
      applyStimulus(1, -16384, 8192, 1, 0, 0);
      checkOutput("q2_x", x_out, 8192);
      checkOutput("q2_y", y_out, 16384);
      applyStimulus(1, -32768, -100, 1, 0, 0);
      checkOutput("q3_x", x_out, 32767);
      checkOutput("q3_y", y_out, 100);
      checkOutput("q23_head", quadrant_out, 2);
      applyStimulus(0, 0, 0, 1, 1, 0);
      checkOutput("q23_second", quadrant_out, 3);
      applyStimulus(0, 0, 0, 1, 1, 0);
      checkOutput("q23_empty", tag_empty, 1);

      $display("[TB] axis boundaries");
      applyStimulus(1, 0, 0, 1, 0, 0);
      checkOutput("zero_x", x_out, 0);
      checkOutput("zero_y", y_out, 0);
      applyStimulus(1, 0, -5, 1, 0, 0);
      checkOutput("negy_x", x_out, 5);
      checkOutput("negy_y", y_out, 0);
      applyStimulus(1, -5, 0, 1, 0, 0);
      checkOutput("negx_x", x_out, 0);
      checkOutput("negx_y", y_out, 5);
      checkOutput("axis_tag1", quadrant_out, 1);
      applyStimulus(0, 0, 0, 1, 1, 0);
      checkOutput("axis_tag4", quadrant_out, 4);
      applyStimulus(0, 0, 0, 1, 1, 0);
      checkOutput("axis_tag2", quadrant_out, 2);
      applyStimulus(0, 0, 0, 1, 1, 0);
      checkOutput("axis_empty", tag_empty, 1);

      $display("[TB] backpressure");
      applyStimulus(0, 0, 0, 1, 0, 1);
      applyStimulus(1, 1000, 2000, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1, -3000, 4000, 0, 0, 0);
         checkOutput("bp_in_ready", in_ready, 0);
         checkOutput("bp_x_held", x_out, 1000);
         checkOutput("bp_y_held", y_out, 2000);
         checkOutput("bp_valid_held", out_valid, 1);
      end
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, randCoord(), randCoord(), 1, 0, 0);
         checkOutput("bp_stream_valid", out_valid, 1);
      end
      checkOutput("bp_tag_count", m_q.size(), 5);

      $display("[TB] fill and overdrain the tag FIFO");
      applyStimulus(0, 0, 0, 1, 0, 1);
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1, randCoord(), randCoord(), 1, 0, 0);
      end
      checkOutput("full_flag", tag_full, 1);
      checkOutput("full_in_ready", in_ready, 0);
      applyStimulus(1, 7, 7, 1, 0, 0);
      checkOutput("full_blocked", tag_full, 1);
      applyStimulus(0, 0, 0, 1, 1, 0);
      checkOutput("full_reopen", in_ready, 1);
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(0, 0, 0, 1, 1, 0);
      end
      checkOutput("drain_empty", tag_empty, 1);
      checkOutput("drain_err", tag_err, 1);

      $display("[TB] mid-stream reset");
      applyStimulus(1, 11, -22, 1, 0, 0);
      applyStimulus(1, -33, 44, 1, 0, 0);
      applyStimulus(1, -55, -66, 1, 0, 0);
      checkOutput("pre_rst_valid", out_valid, 1);
      applyStimulus(1, 99, 99, 1, 0, 1);
      checkOutput("post_rst_valid", out_valid, 0);
      checkOutput("post_rst_empty", tag_empty, 1);
      checkOutput("post_rst_err", tag_err, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("post_rst_in_ready", in_ready, 1);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 400; i++) begin
         applyStimulus($urandom_range(0, 9) < 7, randCoord(), randCoord(),
                       $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4,
                       $urandom_range(0, 63) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
